// File: rtl/alu_uart_interface.sv
// Frames three UART bytes (A, B, opcode) into ALU operands and sends the result byte back.
// Optional inter-byte timeout enabled by defining ALU_IF_TIMEOUT_EN.
module alu_uart_interface #(
    parameter int DBIT           = 8,
    parameter int OP_W           = 6,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int TO_BIT         = 20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd_uart,
    input  logic            tx_full,
    output logic            wr_uart,
    output logic [DBIT-1:0] w_data,
    output logic [DBIT-1:0] alu_a,
    output logic [DBIT-1:0] alu_b,
    output logic [OP_W-1:0] alu_op,
    input  logic [DBIT-1:0] alu_result,
    output logic            timeout_err
);

    typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, SEND} state_t;

    state_t state;
    logic   accept;
    logic   waiting;
    logic   to_hit;

    // The pop is registered, so the FIFO head is stale in the cycle rd_uart is high.
    assign accept  = !rx_empty && !rd_uart;
    assign waiting = (state == GET_B || state == GET_OP) && rx_empty;

`ifdef ALU_IF_TIMEOUT_EN
    localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT_CYCLES - 1);

    logic [TO_BIT-1:0] to_cnt;

    assign to_hit = waiting && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= to_hit;
            if (to_hit || accept || !(state == GET_B || state == GET_OP)) begin
                to_cnt <= '0;
            end else if (waiting) begin
                to_cnt <= to_cnt + TO_BIT'(1);
            end
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg  = ^{TIMEOUT_CYCLES, TO_BIT, waiting};
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= GET_A;
            rd_uart <= 1'b0;
            wr_uart <= 1'b0;
            w_data  <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
        end else begin
            rd_uart <= 1'b0;
            wr_uart <= 1'b0;
            case (state)
                GET_A: begin
                    if (accept) begin
                        alu_a   <= r_data;
                        rd_uart <= 1'b1;
                        state   <= GET_B;
                    end
                end
                GET_B: begin
                    if (accept) begin
                        alu_b   <= r_data;
                        rd_uart <= 1'b1;
                        state   <= GET_OP;
                    end else if (to_hit) begin
                        state <= GET_A;
                    end
                end
                GET_OP: begin
                    if (accept) begin
                        alu_op  <= r_data[OP_W-1:0];
                        rd_uart <= 1'b1;
                        state   <= EXEC;
                    end else if (to_hit) begin
                        state <= GET_A;
                    end
                end
                EXEC: begin
                    w_data <= alu_result;
                    state  <= SEND;
                end
                SEND: begin
                    if (!tx_full) begin
                        wr_uart <= 1'b1;
                        state   <= GET_A;
                    end
                end
                default: state <= GET_A;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: queue-modelled UART FIFOs, a model ALU and a result scoreboard.
module tb_alu_uart_interface;

    localparam int DBIT   = 8;
    localparam int OP_W   = 6;
    localparam int TO_CYC = 100;
    localparam int TO_BIT = 20;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            rx_empty = 1'b1;
    logic [DBIT-1:0] r_data = '0;
    logic            rd_uart;
    logic            tx_full = 1'b0;
    logic            wr_uart;
    logic [DBIT-1:0] w_data;
    logic [DBIT-1:0] alu_a;
    logic [DBIT-1:0] alu_b;
    logic [OP_W-1:0] alu_op;
    logic [DBIT-1:0] alu_result;
    logic            timeout_err;

    alu_uart_interface #(
        .DBIT          (DBIT),
        .OP_W          (OP_W),
        .TIMEOUT_CYCLES(TO_CYC),
        .TO_BIT        (TO_BIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_empty   (rx_empty),
        .r_data     (r_data),
        .rd_uart    (rd_uart),
        .tx_full    (tx_full),
        .wr_uart    (wr_uart),
        .w_data     (w_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_op);

    logic [7:0] rxq[$];
    logic [7:0] expq[$];
    int vectors = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int to_cnt = 0;
    int cyc = 0;
    int last_rd_cyc = 0;
    int last_lat = 0;
    int txf_mode = 0;
    logic prev_rd = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void refresh();
        rx_empty = (rxq.size() == 0);
        r_data   = (rxq.size() == 0) ? 8'h00 : rxq[0];
    endfunction

    // Monitor and FIFO model: DUT outputs are stable mid-cycle, pops land before the next edge.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            check("rd_wr_same_cycle", {31'b0, rd_uart & wr_uart}, 32'd0);
            check("rd_back_to_back", {31'b0, rd_uart & prev_rd}, 32'd0);
            check("rd_while_empty", {31'b0, rd_uart & rx_empty}, 32'd0);
        end
        prev_rd = rd_uart;
        if (rd_uart) begin
            rd_cnt++;
            last_rd_cyc = cyc;
            if (rxq.size() > 0) void'(rxq.pop_front());
        end
        if (wr_uart) begin
            wr_cnt++;
            last_lat = cyc - last_rd_cyc;
            check("wr_expected", {31'b0, expq.size() != 0}, 32'd1);
            if (expq.size() != 0) check("w_data", {24'b0, w_data}, {24'b0, expq.pop_front()});
        end
        if (timeout_err) to_cnt++;
        tx_full = (txf_mode == 2) ? ($urandom_range(0, 3) == 0) : (txf_mode == 1);
        refresh();
    end

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        #1;
        rxq.push_back(b);
        refresh();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input int gap);
        expq.push_back(alu_f(a, b, op[5:0]));
        push(a);
        idle(gap);
        push(b);
        idle(gap);
        push(op);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int left = budget;
        while ((expq.size() != 0 || rxq.size() != 0) && left > 0) begin
            @(negedge clk);
            left--;
        end
        check(tag, expq.size() + rxq.size(), 32'd0);
        idle(3);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1;
        reset = 1'b1;
        idle(n);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, wr0;
        logic [7:0] ops[5];
        ops[0] = 8'h20; ops[1] = 8'h22; ops[2] = 8'h24; ops[3] = 8'h25; ops[4] = 8'h26;

        // Reset state
        idle(3);
        check("rst_data", {8'h00, w_data, alu_a, alu_b}, 32'd0);
        check("rst_ctrl", {23'b0, rd_uart, wr_uart, timeout_err, alu_op}, 32'd0);
        #1;
        reset = 1'b0;

        // ADD 5+3: three pops, result two cycles after the opcode pop
        rd0 = rd_cnt; wr0 = wr_cnt;
        frame(8'h05, 8'h03, 8'h20, 0);
        wait_done("add_drain", 100);
        check("add_rd_count", rd_cnt - rd0, 32'd3);
        check("add_wr_count", wr_cnt - wr0, 32'd1);
        check("add_latency", last_lat, 32'd2);
        check("add_w_data", {24'b0, w_data}, 32'h08);

        // tx_full backpressure on OR frame
        txf_mode = 1;
        wr0 = wr_cnt;
        frame(8'hF0, 8'h0F, 8'h25, 0);
        idle(50);
        check("bp_no_wr", wr_cnt - wr0, 32'd0);
        check("bp_w_data_held", {24'b0, w_data}, 32'hFF);
        txf_mode = 0;
        wait_done("bp_drain", 50);
        check("bp_wr_count", wr_cnt - wr0, 32'd1);

        // Upper opcode bits ignored
        frame(8'h09, 8'h04, 8'hE2, 1);
        wait_done("op_mask_drain", 100);
        check("op_mask", {26'b0, alu_op}, 32'h22);

        // Reset mid-frame discards the partial frame
        wr0 = wr_cnt;
        push(8'h01);
        push(8'h02);
        idle(6);
        do_reset(2);
        frame(8'h04, 8'h04, 8'h22, 0);
        wait_done("midrst_drain", 100);
        check("midrst_wr_count", wr_cnt - wr0, 32'd1);
        check("midrst_alu_a", {24'b0, alu_a}, 32'h04);

        // Reset while a result waits in SEND
        txf_mode = 1;
        wr0 = wr_cnt;
        frame(8'h11, 8'h22, 8'h20, 0);
        idle(10);
        do_reset(2);
        expq.delete();
        txf_mode = 0;
        idle(10);
        check("sendrst_no_wr", wr_cnt - wr0, 32'd0);
        check("sendrst_w_data", {24'b0, w_data}, 32'h00);

        // Inter-byte timeout
        to_cnt = 0;
        push(8'h07);
        idle(TO_CYC + 10);
`ifdef ALU_IF_TIMEOUT_EN
        check("timeout_pulses", to_cnt, 32'd1);
        frame(8'h01, 8'h01, 8'h20, 0);
        wait_done("timeout_drain", 100);
        check("timeout_w_data", {24'b0, w_data}, 32'h02);
`else
        check("timeout_pulses", to_cnt, 32'd0);
        expq.push_back(8'h0A);
        push(8'h03);
        push(8'h20);
        wait_done("notimeout_drain", 100);
        check("notimeout_w_data", {24'b0, w_data}, 32'h0A);
`endif

        // Random frames with random gaps and random tx_full
        txf_mode = 2;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] op;
            op = ops[$urandom_range(0, 4)] | (8'($urandom_range(0, 3)) << 6);
            frame(8'($urandom), 8'($urandom), op, $urandom_range(0, 3));
        end
        wait_done("rand_drain", 2000);
        txf_mode = 0;
        idle(3);

        // Ten frames preloaded back to back
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(negedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] a, b, op;
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = ops[i % 5];
            expq.push_back(alu_f(a, b, op[5:0]));
            rxq.push_back(a);
            rxq.push_back(b);
            rxq.push_back(op);
        end
        refresh();
        wait_done("burst_drain", 500);
        check("burst_rd_count", rd_cnt - rd0, 32'd30);
        check("burst_wr_count", wr_cnt - wr0, 32'd10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/alu_uart_interface.md
ALU_UART_INTERFACE -- requirements
Module: alu_uart_interface

Interface
REQ-001 The module SHALL have parameter DBIT, default 8, giving the data byte width.
REQ-002 The module SHALL have parameter OP_W, default 6, giving the ALU opcode width (OP_W <= DBIT).
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, giving the inter-byte timeout in clk cycles.
REQ-004 The module SHALL have parameter TO_BIT, default 20, giving the timeout counter width.
REQ-005 The module SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-006 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 The module SHALL have port rx_empty  input  1  UART receive FIFO empty.
REQ-008 The module SHALL have port r_data  input  DBIT  head word of UART receive FIFO; valid whenever rx_empty=0.
REQ-009 The module SHALL have port rd_uart  output  1  one-cycle pop of the receive FIFO.
REQ-010 The module SHALL have port tx_full  input  1  UART transmit FIFO full.
REQ-011 The module SHALL have port wr_uart  output  1  one-cycle push into the transmit FIFO.
REQ-012 The module SHALL have port w_data  output  DBIT  byte pushed with wr_uart.
REQ-013 The module SHALL have ports alu_a and alu_b  output  DBIT  registered ALU operands.
REQ-014 The module SHALL have port alu_op  output  OP_W  registered ALU opcode.
REQ-015 The module SHALL have port alu_result  input  DBIT  combinational ALU result.
REQ-016 The module SHALL have port timeout_err  output  1  one-cycle pulse on an aborted frame.

Function
REQ-017 The FSM SHALL have states GET_A, GET_B, GET_OP, EXEC and SEND, entering GET_A from reset.
REQ-018 In GET_A, GET_B or GET_OP with rx_empty=0, the module SHALL assert rd_uart for exactly one cycle, latch r_data into alu_a, alu_b or alu_op (low OP_W bits; upper bits ignored), and advance GET_A->GET_B->GET_OP->EXEC.
REQ-019 The module SHALL assert rd_uart at most once per byte, never in two consecutive cycles, and never while rx_empty=1.
REQ-020 EXEC SHALL last one cycle, register alu_result into w_data, and go to SEND; the operands are therefore stable for at least one full cycle before capture.
REQ-021 In SEND with tx_full=0, the module SHALL assert wr_uart for one cycle and return to GET_A; with tx_full=1, it SHALL hold SEND with wr_uart=0 and w_data unchanged.
REQ-022 Latency SHALL be two cycles from the rd_uart cycle of the opcode byte to the earliest wr_uart cycle.
REQ-023 alu_a, alu_b, alu_op and w_data SHALL hold their values until overwritten by a later frame.
REQ-024 Received bytes SHALL be consumed strictly in order; no byte is dropped or duplicated.
REQ-025 rd_uart and wr_uart SHALL never be asserted in the same cycle.

Reset
REQ-026 While reset=1, the module SHALL be in state GET_A with rd_uart=0, wr_uart=0, timeout_err=0, w_data=0, alu_a=0, alu_b=0, alu_op=0 and the timeout counter=0.
REQ-027 Reset asserted mid-frame or in SEND SHALL discard the partial frame or pending result without asserting wr_uart.

Configuration
REQ-028 With macro ALU_IF_TIMEOUT_EN defined, a counter SHALL run in GET_B and GET_OP while rx_empty=1 and clear on every byte accepted.
REQ-029 When that counter reaches TIMEOUT_CYCLES-1, the module SHALL pulse timeout_err for one cycle, return to GET_A and discard the partial frame.
REQ-030 Without ALU_IF_TIMEOUT_EN, the counter SHALL be absent, timeout_err SHALL be tied to 0, and the module SHALL wait indefinitely in any GET_* state.

Verification
REQ-031 Bytes 0x05, 0x03, 0x20 with a model ALU (0x20=ADD) SHALL give exactly 3 rd_uart pulses, then one wr_uart pulse with w_data=0x08 two cycles after the third pop.
REQ-032 With tx_full=1 held for 50 cycles after the frame 0xF0, 0x0F, 0x25 (OR), the bench SHALL see no wr_uart; when tx_full is released, it SHALL see one wr_uart with w_data=0xFF.
REQ-033 Opcode byte 0xE2 SHALL give alu_op=0x22, ignoring the upper bits.
REQ-034 Bytes 0x01, 0x02 followed by reset mid-frame, then frame 0x04, 0x04, 0x22 (SUB), SHALL give a single wr_uart with w_data=0x00 and alu_a=0x04.
REQ-035 With ALU_IF_TIMEOUT_EN and TIMEOUT_CYCLES=100, byte 0x07 followed by 100 idle cycles SHALL give one timeout_err pulse; the next frame 0x01, 0x01, 0x20 SHALL then give w_data=0x02.
REQ-036 Ten back-to-back frames preloaded in the receive FIFO SHALL give ten results in order, with no consecutive rd_uart cycles.
